// File: rtl/vdec_mc_ctrl_if.sv
// Handshake bundle between the motion-compensation job controller and its
// requester / step engines.
interface vdec_mc_ctrl_if #(
  parameter int SEL_W = 2
);
  logic             start;
  logic [1:0]       mode;
  logic [SEL_W-1:0] crc_num;
  logic             abort;
  logic             fwd_start;
  logic             bwd_start;
  logic             crc_start;
  logic             ser_start;
  logic             fwd_done;
  logic             bwd_done;
  logic             crc_done;
  logic             ser_done;
  logic             crc_match;
  logic [SEL_W-1:0] crc_sel;
  logic             busy;
  logic             done;
  logic [1:0]       status;
  logic             pend_ovf;
  logic [2:0]       fsm_out;

  modport master (
    output start, mode, crc_num, abort,
    output fwd_done, bwd_done, crc_done, ser_done, crc_match,
    input  fwd_start, bwd_start, crc_start, ser_start,
    input  crc_sel, busy, done, status, pend_ovf, fsm_out
  );

  modport slave (
    input  start, mode, crc_num, abort,
    input  fwd_done, bwd_done, crc_done, ser_done, crc_match,
    output fwd_start, bwd_start, crc_start, ser_start,
    output crc_sel, busy, done, status, pend_ovf, fsm_out
  );
endinterface

// File: rtl/vdec_mc_ctrl.sv
// Job sequencer: FWD -> BWD -> (CRC candidates) -> SER -> FINISH, with a one-deep
// pending request. Define VDEC_MC_CTRL_TMO_EN to compile in the per-step watchdog.
module vdec_mc_ctrl #(
  parameter int          SEL_W   = 2,
  parameter int          TMO_W   = 16,
  parameter int unsigned TMO_MAX = 16'hFFFF
) (
  input logic           clk,
  input logic           rst_n,
  vdec_mc_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FWD    = 3'd1,
    S_BWD    = 3'd2,
    S_CRC    = 3'd3,
    S_SER    = 3'd4,
    S_FINISH = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       status_q, status_d;
  logic [SEL_W-1:0] crc_sel_q, crc_sel_d;
  logic [1:0]       job_mode_q, job_mode_d;
  logic [SEL_W-1:0] job_num_q, job_num_d;
  logic             pend_q, pend_d;
  logic [1:0]       pend_mode_q, pend_mode_d;
  logic [SEL_W-1:0] pend_num_q, pend_num_d;
  logic             fwd_start_q, bwd_start_q, crc_start_q, ser_start_q, pend_ovf_q;
  logic             fwd_go, bwd_go, crc_go, ser_go, ovf_d;
  logic             tmo_hit;

`ifdef VDEC_MC_CTRL_TMO_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             in_step;

  assign in_step = (state_q == S_FWD) || (state_q == S_BWD) ||
                   (state_q == S_CRC) || (state_q == S_SER);
  // Hit one count early so the step occupies exactly TMO_MAX cycles.
  assign tmo_hit = in_step && (tmo_q == TMO_W'(TMO_MAX - 1));

  always_comb begin
    tmo_d = '0;
    if (in_step && (state_d == state_q) && !crc_go) tmo_d = tmo_q + TMO_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    crc_sel_d   = crc_sel_q;
    job_mode_d  = job_mode_q;
    job_num_d   = job_num_q;
    pend_d      = pend_q;
    pend_mode_d = pend_mode_q;
    pend_num_d  = pend_num_q;
    fwd_go      = 1'b0;
    bwd_go      = 1'b0;
    crc_go      = 1'b0;
    ser_go      = 1'b0;
    ovf_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          job_mode_d = pend_mode_q;
          job_num_d  = pend_num_q;
          pend_d     = 1'b0;
          state_d    = S_FWD;
          fwd_go     = 1'b1;
          crc_sel_d  = '0;
        end else if (bus.start) begin
          job_mode_d = bus.mode;
          job_num_d  = bus.crc_num;
          state_d    = S_FWD;
          fwd_go     = 1'b1;
          crc_sel_d  = '0;
        end
      end
      S_FWD, S_BWD, S_CRC, S_SER: begin
        if (bus.abort) begin
          state_d  = S_FINISH;
          status_d = 2'b11;
        end else if (tmo_hit) begin
          state_d  = S_FINISH;
          status_d = 2'b10;
        end else begin
          case (state_q)
            S_FWD: if (bus.fwd_done) begin
              state_d = S_BWD;
              bwd_go  = 1'b1;
            end
            S_BWD: if (bus.bwd_done) begin
              if (job_mode_q == 2'b01 || job_mode_q == 2'b10) begin
                state_d   = S_CRC;
                crc_go    = 1'b1;
                crc_sel_d = '0;
              end else begin
                state_d = S_SER;
                ser_go  = 1'b1;
              end
            end
            S_CRC: if (bus.crc_done) begin
              if (bus.crc_match) begin
                state_d = S_SER;
                ser_go  = 1'b1;
              end else if (job_mode_q == 2'b10 && crc_sel_q != job_num_q) begin
                crc_go    = 1'b1;
                crc_sel_d = crc_sel_q + SEL_W'(1);
              end else begin
                state_d  = S_FINISH;
                status_d = 2'b01;
              end
            end
            default: if (bus.ser_done) begin
              state_d  = S_FINISH;
              status_d = 2'b00;
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A start not taken directly from IDLE goes to the pending slot; in IDLE the
    // slot is being drained this cycle, so it can always absorb the new request.
    if (bus.start && !(state_q == S_IDLE && !pend_q)) begin
      if (pend_q && state_q != S_IDLE) begin
        ovf_d = 1'b1;
      end else begin
        pend_d      = 1'b1;
        pend_mode_d = bus.mode;
        pend_num_d  = bus.crc_num;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      status_q    <= 2'b00;
      crc_sel_q   <= '0;
      job_mode_q  <= 2'b00;
      job_num_q   <= '0;
      pend_q      <= 1'b0;
      pend_mode_q <= 2'b00;
      pend_num_q  <= '0;
      fwd_start_q <= 1'b0;
      bwd_start_q <= 1'b0;
      crc_start_q <= 1'b0;
      ser_start_q <= 1'b0;
      pend_ovf_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      crc_sel_q   <= crc_sel_d;
      job_mode_q  <= job_mode_d;
      job_num_q   <= job_num_d;
      pend_q      <= pend_d;
      pend_mode_q <= pend_mode_d;
      pend_num_q  <= pend_num_d;
      fwd_start_q <= fwd_go;
      bwd_start_q <= bwd_go;
      crc_start_q <= crc_go;
      ser_start_q <= ser_go;
      pend_ovf_q  <= ovf_d;
    end
  end

  assign bus.fwd_start = fwd_start_q;
  assign bus.bwd_start = bwd_start_q;
  assign bus.crc_start = crc_start_q;
  assign bus.ser_start = ser_start_q;
  assign bus.crc_sel   = crc_sel_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_FINISH);
  assign bus.status    = status_q;
  assign bus.pend_ovf  = pend_ovf_q;
  assign bus.fsm_out   = state_q;
endmodule

// File: tb/tb_vdec_mc_ctrl.sv
// Scoreboard bench for vdec_mc_ctrl: jobs push expected outcomes, the monitor pops
// and compares them on each done pulse; a responder plays the step engines.
module tb_vdec_mc_ctrl;
  localparam int SEL_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vdec_mc_ctrl_if #(.SEL_W(SEL_W)) bus ();

  vdec_mc_ctrl #(.SEL_W(SEL_W), .TMO_W(16), .TMO_MAX(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int status;
    int fwd, bwd, crc, ser;
    int sel_ser;
    int trace;
    int fwd_cyc;
  } exp_t;

  exp_t sb[$];
  bit   mq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int fwd_lat = 5, bwd_lat = 5, crc_lat = 2, ser_lat = 3;
  bit abort_with_bwd = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t mk_exp(int st, int f, int b, int c, int s, int sel, int tr, int fc);
    exp_t e;
    e.status = st; e.fwd = f; e.bwd = b; e.crc = c; e.ser = s;
    e.sel_ser = sel; e.trace = tr; e.fwd_cyc = fc;
    return e;
  endfunction

  // Monitor / scoreboard
  int m_fwd = 0, m_bwd = 0, m_crc = 0, m_ser = 0, m_sel = 0, m_trace = 0, m_fcyc = 0;
  int ovf_cnt = 0, cyc = 0, last_done_cyc = 0, last_gap = 0, job_no = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_fwd = 0; m_bwd = 0; m_crc = 0; m_ser = 0; m_sel = 0; m_trace = 0; m_fcyc = 0;
      end else begin
        if (bus.fsm_out == 3'd1) m_fcyc++;
        if (bus.fwd_start) begin m_fwd++; last_gap = cyc - last_done_cyc; end
        if (bus.bwd_start) m_bwd++;
        if (bus.crc_start) begin m_crc++; m_trace = (m_trace << 4) | int'(bus.crc_sel); end
        if (bus.ser_start) begin m_ser++; m_sel = int'(bus.crc_sel); end
        if (bus.pend_ovf) ovf_cnt++;
        if (bus.done) begin
          last_done_cyc = cyc;
          if (sb.size() == 0) begin
            check_eq("unexpected_done", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            job_no++;
            check_eq($sformatf("j%0d_status", job_no), int'(bus.status), e.status);
            check_eq($sformatf("j%0d_fwd_starts", job_no), m_fwd, e.fwd);
            check_eq($sformatf("j%0d_bwd_starts", job_no), m_bwd, e.bwd);
            check_eq($sformatf("j%0d_crc_starts", job_no), m_crc, e.crc);
            check_eq($sformatf("j%0d_ser_starts", job_no), m_ser, e.ser);
            check_eq($sformatf("j%0d_crc_sel_trace", job_no), m_trace, e.trace);
            if (e.ser > 0) check_eq($sformatf("j%0d_sel_in_ser", job_no), m_sel, e.sel_ser);
            if (e.fwd_cyc >= 0) check_eq($sformatf("j%0d_fwd_cycles", job_no), m_fcyc, e.fwd_cyc);
            $display("job %0d done: status=%0d fwd=%0d bwd=%0d crc=%0d ser=%0d trace=%0h",
                     job_no, bus.status, m_fwd, m_bwd, m_crc, m_ser, m_trace);
          end
          m_fwd = 0; m_bwd = 0; m_crc = 0; m_ser = 0; m_sel = 0; m_trace = 0; m_fcyc = 0;
        end
      end
    end
  end

  // Step-engine responder
  initial begin
    int t_fwd, t_bwd, t_crc, t_ser;
    bit abort_by_rsp;
    t_fwd = 0; t_bwd = 0; t_crc = 0; t_ser = 0; abort_by_rsp = 0;
    bus.fwd_done = 0; bus.bwd_done = 0; bus.crc_done = 0; bus.ser_done = 0;
    bus.crc_match = 0;
    forever begin
      @(posedge clk); #1;
      bus.fwd_done = 0; bus.bwd_done = 0; bus.crc_done = 0; bus.ser_done = 0;
      if (abort_by_rsp) begin bus.abort = 0; abort_by_rsp = 0; end
      if (!rst_n) begin
        t_fwd = 0; t_bwd = 0; t_crc = 0; t_ser = 0;
      end else begin
        if (t_fwd > 0) begin t_fwd--; if (t_fwd == 0) bus.fwd_done = 1; end
        if (t_bwd > 0) begin
          t_bwd--;
          if (t_bwd == 0) begin
            bus.bwd_done = 1;
            if (abort_with_bwd) begin bus.abort = 1; abort_by_rsp = 1; end
          end
        end
        if (t_crc > 0) begin
          t_crc--;
          if (t_crc == 0) begin
            bus.crc_done  = 1;
            bus.crc_match = (mq.size() > 0) ? mq.pop_front() : 1'b0;
          end
        end
        if (t_ser > 0) begin t_ser--; if (t_ser == 0) bus.ser_done = 1; end
        if (bus.fwd_start && fwd_lat > 0) t_fwd = fwd_lat;
        if (bus.bwd_start && bwd_lat > 0) t_bwd = bwd_lat;
        if (bus.crc_start && crc_lat > 0) t_crc = crc_lat;
        if (bus.ser_start && ser_lat > 0) t_ser = ser_lat;
      end
    end
  end

  task automatic start_job(input logic [1:0] m, input int n, input exp_t e, input bit push);
    bus.start   = 1;
    bus.mode    = m;
    bus.crc_num = n[SEL_W-1:0];
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    bus.start = 0;
  endtask

  task automatic wait_drain(input string tag, input int max_cyc);
    int k = 0;
    while ((sb.size() != 0 || bus.busy) && k < max_cyc) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq({tag, "_drained"}, int'(k < max_cyc), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_fsm"},      int'(bus.fsm_out), 0);
    check_eq({tag, "_busy"},     int'(bus.busy), 0);
    check_eq({tag, "_done"},     int'(bus.done), 0);
    check_eq({tag, "_status"},   int'(bus.status), 0);
    check_eq({tag, "_crc_sel"},  int'(bus.crc_sel), 0);
    check_eq({tag, "_pend_ovf"}, int'(bus.pend_ovf), 0);
    check_eq({tag, "_starts"},
             int'({bus.fwd_start, bus.bwd_start, bus.crc_start, bus.ser_start}), 0);
  endtask

  initial begin
    int ovf0, k;
    bus.start = 0; bus.mode = 0; bus.crc_num = 0; bus.abort = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1;
    @(posedge clk); #1;

    // Plain job, no CRC
    start_job(2'b00, 0, mk_exp(0, 1, 1, 0, 1, 0, 0, -1), 1);
    wait_drain("mode00", 200);

    // Multi-candidate: third candidate matches
    mq.push_back(0); mq.push_back(0); mq.push_back(1);
    start_job(2'b10, 2, mk_exp(0, 1, 1, 3, 1, 2, 'h012, -1), 1);
    wait_drain("multi_match", 200);

    // Multi-candidate exhausted, then single-CRC mismatch, then single-CRC match
    mq.push_back(0); mq.push_back(0);
    start_job(2'b10, 1, mk_exp(1, 1, 1, 2, 0, 0, 'h01, -1), 1);
    wait_drain("multi_fail", 200);
    mq.push_back(0);
    start_job(2'b01, 3, mk_exp(1, 1, 1, 1, 0, 0, 0, -1), 1);
    wait_drain("single_fail", 200);
    mq.push_back(1);
    start_job(2'b01, 0, mk_exp(0, 1, 1, 1, 1, 0, 0, -1), 1);
    wait_drain("single_ok", 200);
    start_job(2'b11, 3, mk_exp(0, 1, 1, 0, 1, 0, 0, -1), 1);
    wait_drain("mode11", 200);

    // Pending request plus one dropped request
    ovf0 = ovf_cnt;
    start_job(2'b00, 0, mk_exp(0, 1, 1, 0, 1, 0, 0, -1), 1);
    mq.push_back(0); mq.push_back(1);
    start_job(2'b10, 1, mk_exp(0, 1, 1, 2, 1, 1, 'h01, -1), 1);
    start_job(2'b00, 0, mk_exp(0, 0, 0, 0, 0, 0, 0, -1), 0);
    wait_drain("pending", 400);
    check_eq("pend_ovf_pulses", ovf_cnt - ovf0, 1);
    check_eq("pending_fwd_gap", last_gap, 2);

    // Abort coincident with bwd_done
    abort_with_bwd = 1;
    start_job(2'b10, 0, mk_exp(3, 1, 1, 0, 0, 0, 0, -1), 1);
    wait_drain("abort_bwd", 200);
    abort_with_bwd = 0;

    // Reset while waiting in CRC with a pending request queued
    crc_lat = 0;
    start_job(2'b10, 3, mk_exp(0, 0, 0, 0, 0, 0, 0, -1), 0);
    k = 0;
    while (bus.fsm_out != 3'd3 && k < 100) begin @(posedge clk); #1; k++; end
    check_eq("reach_crc", int'(bus.fsm_out), 3);
    start_job(2'b00, 0, mk_exp(0, 0, 0, 0, 0, 0, 0, -1), 0);
    rst_n = 0;
    #1;
    check_reset_outputs("midjob_rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    crc_lat = 2;
    mq.delete();
    repeat (10) @(posedge clk);
    #1;
    check_eq("post_rst_idle", int'(bus.busy), 0);

    // Withheld fwd_done
    fwd_lat = 0;
`ifdef VDEC_MC_CTRL_TMO_EN
    start_job(2'b00, 0, mk_exp(2, 1, 0, 0, 0, 0, 0, 8), 1);
    wait_drain("timeout", 100);
`else
    start_job(2'b00, 0, mk_exp(3, 1, 0, 0, 0, 0, 0, -1), 1);
    repeat (40) @(posedge clk);
    #1;
    check_eq("no_tmo_busy", int'(bus.busy), 1);
    bus.abort = 1;
    @(posedge clk); #1;
    bus.abort = 0;
    wait_drain("no_tmo_abort", 50);
`endif
    fwd_lat = 5;
    check_eq("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vdec_mc_ctrl.md
VDEC_MC_CTRL -- requirements
Module: vdec_mc_ctrl

Interface
REQ-001 SHALL have parameter SEL_W, default 2: CRC candidate index width; up to 2**SEL_W candidates.
REQ-002 SHALL have parameter TMO_W, default 16: watchdog counter width.
REQ-003 SHALL have parameter TMO_MAX, default 16'hFFFF: per-step cycle limit before timeout.
REQ-004 clk  in  1  single clock, all flops on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle job request.
REQ-007 mode  in  2  job mode, sampled with accepted start: 00 no CRC, 01 single CRC, 10 multi-candidate CRC, 11 treated as 00.
REQ-008 crc_num  in  SEL_W  candidate count minus one, sampled with accepted start.
REQ-009 abort  in  1  cancel current job.
REQ-010 fwd_start/bwd_start/crc_start/ser_start  out  1 each  registered one-cycle step start pulses.
REQ-011 fwd_done/bwd_done/crc_done/ser_done  in  1 each  step completion pulses.
REQ-012 crc_match  in  1  CRC result, valid with crc_done.
REQ-013 crc_sel  out  SEL_W  active CRC candidate index.
REQ-014 busy  out  1  high when state is not IDLE.
REQ-015 done  out  1  one-cycle pulse in FINISH.
REQ-016 status  out  2  job result, held until next FINISH: 00 ok, 01 CRC fail, 10 timeout, 11 aborted.
REQ-017 pend_ovf  out  1  one-cycle pulse when a start is dropped.
REQ-018 fsm_out  out  3  current state encoding.

Function
REQ-019 States SHALL be IDLE=0, FWD=1, BWD=2, CRC=3, SER=4, FINISH=5; codes 6/7 SHALL return to IDLE next cycle.
REQ-020 IDLE->FWD on start or pending flag; fwd_start SHALL assert the cycle after the transition decision (registered from state/next-state).
REQ-021 FWD->BWD on fwd_done with bwd_start pulse; BWD on bwd_done -> SER if mode 00/11, else CRC with crc_start, crc_sel=0.
REQ-022 CRC on crc_done: match -> SER with ser_start; mismatch in mode 01 -> FINISH status 01; mismatch in mode 10 with crc_sel<crc_num -> stay CRC, crc_sel+1, new crc_start; mismatch with crc_sel==crc_num -> FINISH status 01.
REQ-023 SER on ser_done -> FINISH status 00; FINISH -> IDLE unconditionally after one cycle.
REQ-024 crc_sel SHALL hold during SER so downstream sees the matching candidate; cleared on entry to FWD.
REQ-025 start while busy SHALL set a one-deep pending flag; start while pending already set SHALL pulse pend_ovf and be dropped; pending flag and its mode/crc_num copy SHALL be consumed on IDLE->FWD.
REQ-026 start in FINISH cycle SHALL be treated as pending, FWD entered two cycles later.
REQ-027 abort in any non-IDLE, non-FINISH state SHALL force FINISH, status 11, no further step starts; abort takes priority over simultaneous done inputs; abort in IDLE/FINISH ignored.
REQ-028 done inputs not matching the current state SHALL be ignored.

Reset
REQ-029 On rst_n low: state IDLE, all start pulses 0, done 0, pend_ovf 0, status 00, crc_sel 0, pending flag 0, watchdog 0.
REQ-030 Reset mid-job SHALL discard the job and the pending request without emitting done.

Configuration
REQ-031 Macro VDEC_MC_CTRL_TMO_EN SHALL compile in the watchdog: counter clears on every state change, increments in FWD/BWD/CRC/SER, reaching TMO_MAX forces FINISH with status 10 (abort priority over timeout).
REQ-032 Without VDEC_MC_CTRL_TMO_EN no counter SHALL exist, status 10 SHALL never occur, steps wait indefinitely.

Verification
REQ-033 mode 00, start, fwd_done@+5, bwd_done@+5, ser_done@+3 -> pulses fwd/bwd/ser_start once each, no crc_start, done one cycle, status 00.
REQ-034 mode 10, crc_num 2, crc_match 0,0,1 -> three crc_start pulses, crc_sel 0,1,2, ser_start, status 00, crc_sel=2 in SER.
REQ-035 mode 10, crc_num 1, two mismatches -> FINISH, status 01, no ser_start; mode 01 single mismatch -> status 01.
REQ-036 start during FWD, then another start -> pend_ovf pulse once, second job runs immediately after FINISH with first-latched mode.
REQ-037 abort coincident with bwd_done -> FINISH next, status 11, no crc_start/ser_start; rst_n low during CRC -> all outputs at reset values.
REQ-038 With VDEC_MC_CTRL_TMO_EN, TMO_MAX=8, withhold fwd_done -> FINISH after 8 FWD cycles, status 10; without macro busy stays high.
